// File: rtl/rsp_fifo.sv
// rsp_fifo: response buffer sitting between the mmu_tree response arbiter and
// the host. One word can be accepted per cycle. The read side is
// first-word-fall-through: the head word is presented on rd_data while
// rd_valid is high, and it is consumed on a cycle where rd_ready is also high.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (control state only)
//   wr_en        write strobe; wr_data is sampled when it is high
//   wr_data      response word {fail_reason, fail, page_idx, id}
//   almost_full  free slots <= AF_MARGIN; tells the tree to stop issuing
//   full         occupancy == DEPTH
//   rd_valid     head entry present
//   rd_data      head entry, meaningful only while rd_valid is high
//   rd_ready     host accepts the head word when rd_valid is also high
//   data_count   occupancy, 0..DEPTH
//   overflow     sticky flag: at least one write was dropped
//   drop_count   number of dropped writes, saturating at 255
module rsp_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  almost_full,
  output logic                  full,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [PTR_WIDTH:0]    data_count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_AF   = (PTR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  do_wr;
  logic                  do_rd;

  // All flags decode the count register directly, so a write into an empty
  // FIFO only becomes visible on the read side one cycle later.
  assign full        = (count == CNT_FULL);
  assign almost_full = (count >= CNT_AF);
  assign rd_valid    = (count != '0);
  assign data_count  = count;
  assign rd_data     = mem[rd_ptr];

  assign do_rd = rd_valid & rd_ready;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_wr = wr_en & (~full | do_rd);

  // Storage is data only and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A write that finds the FIFO full with no read to make room is lost.
      if (wr_en && full && !do_rd) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule
